// File: rtl/pipe_ctrl_pkg.sv
// Shared defines and constants for the pipeline controller (stall bus range,
// Stop/NoStop levels, exception vector, eret code, stall encodings).
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define StallBus 8:0
`endif

package pipe_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  localparam logic [31:0] ERET_CODE  = 32'h0000000E;

  // Each encoding holds the requesting stage and everything upstream of it.
  localparam logic [`StallBus] STALL_NONE = 9'h000;
  localparam logic [`StallBus] STALL_IF   = 9'h007;
  localparam logic [`StallBus] STALL_ID   = 9'h00F;
  localparam logic [`StallBus] STALL_EX   = 9'h01F;
  localparam logic [`StallBus] STALL_MEM  = 9'h07F;
  localparam logic [`StallBus] STALL_ALL  = 9'h1FF;

  function automatic logic [31:0] redirect_pc(input logic [31:0] code,
                                              input logic [31:0] epc);
    return (code == ERET_CODE) ? epc : EXC_VECTOR;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: RUN/DRAIN/FLUSH FSM with a registered flush.
// Optional stall-cycle counter enabled by macro PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              mem_busy,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  output logic [`StallBus]  stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [31:0]       stall_cnt
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic        flush_q;
  logic        exc_pending;

  assign exc_pending = |excepttype_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      code_q  <= '0;
      epc_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      flush_q <= (state_d == FLUSH);
    end
  end

  // Only RUN accepts an exception; DRAIN/FLUSH keep the first one latched.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    epc_d   = epc_q;
    case (state_q)
      RUN: begin
        if (exc_pending) begin
          code_d  = excepttype_i;
          epc_d   = cp0_epc_i;
          state_d = mem_busy ? DRAIN : FLUSH;
        end
      end
      DRAIN:   if (!mem_busy) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall = STALL_NONE;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (exc_pending)       stall = mem_busy ? STALL_ALL : STALL_NONE;
          else if (stallreq_mem) stall = STALL_MEM;
          else if (stallreq_ex)  stall = STALL_EX;
          else if (stallreq_id)  stall = STALL_ID;
          else if (stallreq_if)  stall = STALL_IF;
        end
        DRAIN:   stall = STALL_ALL;
        default: stall = STALL_NONE;
      endcase
    end
  end

  assign flush  = flush_q;
  assign new_pc = flush_q ? redirect_pc(code_q, epc_q) : 32'h0;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                              stall_cnt_q <= '0;
    else if (stall[0] == Stop && !flush_q) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port stallreq_if, input, 1 bit: fetch stage hold request (icache miss).
REQ-005 Port stallreq_id, input, 1 bit: decode hold request (load-use hazard).
REQ-006 Port stallreq_ex, input, 1 bit: execute hold request (multi-cycle mul/div busy).
REQ-007 Port stallreq_mem, input, 1 bit: memory hold request (dcache miss).
REQ-008 Port mem_busy, input, 1 bit: an outstanding bus transaction cannot be aborted.
REQ-009 Port excepttype_i, input, 32 bits: exception code from the writeback register; zero means none.
REQ-010 Port cp0_epc_i, input, 32 bits: EPC value for eret.
REQ-011 Port stall, output, `StallBus (9 bits): bit k=1 holds stage register k; bit 0 is PC and bit 8 is WB.
REQ-012 Port flush, output, 1 bit: clears all pipeline registers.
REQ-013 Port new_pc, output, 32 bits: redirect target, valid while flush=1.
REQ-014 Port stall_cnt, output, 32 bits: stall-cycle counter (see Configuration).

Function
REQ-015 stall SHALL be combinational from the requests and the FSM state; the highest-index active request wins.
REQ-016 stallreq_mem SHALL drive stall=9'h07F, stallreq_ex 9'h01F, stallreq_id 9'h00F, stallreq_if 9'h007, and no request 9'h000.
REQ-017 Stage k SHALL bubble when stall[k]=1 and stall[k+1]=0; bits set form a contiguous run from bit 0.
REQ-018 The FSM SHALL have three states: RUN, DRAIN, FLUSH.
REQ-019 RUN, excepttype_i!=0 and mem_busy=0: the FSM SHALL go to FLUSH next cycle.
REQ-020 RUN, excepttype_i!=0 and mem_busy=1: the FSM SHALL go to DRAIN, latch excepttype_i and cp0_epc_i, and force stall=9'h1FF.
REQ-021 DRAIN SHALL hold stall=9'h1FF until mem_busy=0, then go to FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle with flush=1 and stall=9'h000, then return to RUN.
REQ-023 The flush asserted in FLUSH SHALL be a registered output.
REQ-024 new_pc SHALL be the latched EPC when the latched code is 32'h0000000E (eret), otherwise 32'hBFC00380.
REQ-025 new_pc SHALL be 32'h0 when flush=0.
REQ-026 Stall requests SHALL be ignored in DRAIN and FLUSH.
REQ-027 A new excepttype_i SHALL be ignored in DRAIN and FLUSH (first exception wins).
REQ-028 An exception SHALL take priority over any stall request in the same cycle.

Reset
REQ-029 rst SHALL force state RUN, flush=0, new_pc=0, stall=9'h000, latched code/EPC=0, stall_cnt=0.
REQ-030 rst asserted in DRAIN or FLUSH SHALL abandon the pending redirect with no flush pulse.

Configuration
REQ-031 Macro PIPE_CTRL_STALL_CNT_EN defined: stall_cnt SHALL increment by 1 each cycle stall[0]=1 and flush=0, wrapping 32'hFFFFFFFF->0.
REQ-032 Macro PIPE_CTRL_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-033 The shared defines header SHALL hold `StallBus, the Stop/NoStop constants, the exception vector 32'hBFC00380 and the eret code 32'h0000000E.
REQ-034 The FSM state encodings SHALL be local parameters of pipe_ctrl; the block SHALL have no sub-modules.

Verification
REQ-035 Bench case: stallreq_id=1 and stallreq_mem=1 in RUN -> stall=9'h07F, flush=0.
REQ-036 Bench case: excepttype_i=32'h1 and mem_busy=0 in cycle t -> flush=1 and new_pc=32'hBFC00380 in cycle t+1 only.
REQ-037 Bench case: excepttype_i=32'hE, cp0_epc_i=32'hBFC00100 -> a one-cycle flush with new_pc=32'hBFC00100.
REQ-038 Bench case: an exception with mem_busy=1 for 3 cycles -> stall=9'h1FF for 3 cycles, then a one-cycle flush using the latched values even though excepttype_i changed meanwhile.
REQ-039 Bench case: rst asserted during DRAIN -> next cycle state RUN, flush never asserted, stall=0.
REQ-040 Bench case, with the macro defined: stallreq_ex held 5 cycles -> stall_cnt=5; preloaded 32'hFFFFFFFF plus 1 stall cycle -> 0.
